// File: rtl/nmea_pkg.sv
// Shared definitions for the NMEA receive path: UART receiver states,
// sentence delimiter characters and the default bit timing.
package nmea_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Characters the sentence parser keys on.
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;

    // 50 MHz system clock, 4800 baud NMEA default.
    localparam int CLKS_PER_BIT_DEF = 10417;

    // Two-out-of-three majority.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // Shift the raw input through two flops; reset to the line's idle level.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/nmea_uart_rx.sv
// 8N1 UART receiver feeding the NMEA parser: false-start rejection,
// 3-sample majority voting per bit and framing-error detection.
module nmea_uart_rx
    import nmea_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_char,
    output logic                 o_finished,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] HALF_P1  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s, rx_d;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] char_q, char_d;
    logic                 fin_q, fin_d;
    logic                 err_q, err_d;
    logic                 vote, at_vote, at_last;

    rx_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // The third sample is rx_s itself in the HALF+1 cycle.
    assign vote    = maj3(smp_q[1], smp_q[0], rx_s);
    assign at_vote = (baud_q == HALF_P1);
    assign at_last = (baud_q == LAST);

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_d    <= 1'b1;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            smp_q   <= '0;
            char_q  <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rx_d    <= rx_s;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            smp_q   <= smp_d;
            char_q  <= char_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    // Frame sequencing: next state, bit timing, sampling and output pulses.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        smp_d   = smp_q;
        char_d  = char_q;
        fin_d   = 1'b0;
        err_d   = 1'b0;

        if (state_q inside {START, DATA, STOP}) begin
            baud_d = at_last ? '0 : baud_q + 1'b1;
            if (baud_q == HALF_M1) smp_d[1] = rx_s;
            if (baud_q == HALF)    smp_d[0] = rx_s;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                // The detect cycle is count 0 of the start bit, so the
                // counter stays aligned with the synchronized bit boundary.
                if (rx_d && !rx_s) begin
                    state_d = START;
                    baud_d  = CW'(1);
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else if (at_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (at_vote) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (at_last) begin
                    if (bit_q == BIT_LAST) state_d = STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is caught.
                if (at_vote) begin
                    baud_d = '0;
                    if (vote) begin
                        char_d  = shreg_q;
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                baud_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_char      = char_q;
    assign o_finished  = fin_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nmea_uart_rx.sv
// Bench for nmea_uart_rx at 16 clocks per bit: directed table, hand-written
// corner sequences and randomized frames against an expected-byte queue.
module tb_nmea_uart_rx;
    import nmea_pkg::*;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = HALF + 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_rx  = 1'b1;
    logic [7:0] o_char;
    logic       o_finished, o_frame_err, o_busy;

    nmea_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .o_char      (o_char),
        .o_finished  (o_finished),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: bytes that must appear, in order, for clean frames.
    logic [7:0] exp_q[$];
    int         exp_err = 0;
    int         n_fin = 0, n_err = 0;
    int         last_fin_cyc = 0, last_err_cyc = 0;
    int         fin_times[$];
    logic       prev_fin = 1'b0;
    int         stop_cyc = 0;

    // Monitor every strobe against the model.
    always @(negedge i_clk) begin
        if (o_finished || o_frame_err)
            chk("pulse_exclusive", 32'(o_finished & o_frame_err), 0);
        if (o_finished) begin
            chk("fin_single_cycle", 32'(prev_fin), 0);
            n_fin++;
            last_fin_cyc = cyc;
            fin_times.push_back(cyc);
            chk("fin_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("fin_char", o_char, exp_q.pop_front());
        end
        if (o_frame_err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        prev_fin = o_finished;
    end

    task automatic drive(input logic b, input int n);
        for (int k = 0; k < n; k++) begin
            i_rx = b;
            @(negedge i_clk);
        end
    endtask

    // One frame; gbit >= 0 inverts data bit gbit for the single cycle goff.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gbit, input int goff);
        if (stop_ok) exp_q.push_back(d);
        else         exp_err++;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) begin
                i_rx = (i == gbit && c == goff) ? ~d[i] : d[i];
                @(negedge i_clk);
            end
        stop_cyc = cyc;
        drive(logic'(stop_ok), CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gbit;
        int         goff;
        logic [7:0] exp_char;
        int         exp_fin;
        int         exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   f0, e0, good;
        bit   seen;
        logic [7:0] d;
        bit   ok;
        int   gb, go, gap;

        vecs[0] = '{CH_DOLLAR, 1'b1, -1, 0,        8'h24, 1, 0};
        vecs[1] = '{8'h00,     1'b1,  3, HALF,     8'h00, 1, 0};
        vecs[2] = '{8'hFF,     1'b1,  5, HALF - 1, 8'hFF, 1, 0};
        vecs[3] = '{8'hA5,     1'b1,  0, HALF + 1, 8'hA5, 1, 0};
        vecs[4] = '{CH_CR,     1'b0, -1, 0,        8'hA5, 0, 1};
        vecs[5] = '{CH_LF,     1'b1,  7, HALF,     8'h0A, 1, 0};
        vecs[6] = '{CH_COMMA,  1'b1,  2, 3,        8'h2C, 1, 0};

        // Reset state.
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_char", o_char, 0);
        chk("rst_fin", 32'(o_finished), 0);
        chk("rst_err", 32'(o_frame_err), 0);
        chk("rst_busy", 32'(o_busy), 0);
        i_rst = 1'b1;
        drive(1'b1, 10);

        // Bad stop bit then a 40-cycle break: one error, o_char untouched.
        f0 = n_fin; e0 = n_err;
        send_frame(8'h47, 1'b0, -1, 0);
        drive(1'b0, 24);
        chk("brk_err_cnt", n_err - e0, 1);
        chk("brk_err_lat", last_err_cyc - stop_cyc, LAT);
        chk("brk_char", o_char, 0);
        chk("brk_busy_low_line", 32'(o_busy), 1);
        drive(1'b1, 20);
        chk("brk_busy_idle", 32'(o_busy), 0);
        chk("brk_err_once", n_err - e0, 1);
        send_frame(CH_STAR, 1'b1, -1, 0);
        drive(1'b1, 20);
        chk("brk_next_char", o_char, 8'h2A);
        chk("brk_fin_cnt", n_fin - f0, 1);

        // False start: 4 low cycles.
        f0 = n_fin; e0 = n_err; seen = 0;
        for (int k = 0; k < 12; k++) begin
            i_rx = (k < 4) ? 1'b0 : 1'b1;
            @(negedge i_clk);
            if (o_busy) seen = 1;
        end
        chk("fs_busy_seen", 32'(seen), 1);
        chk("fs_busy_back", 32'(o_busy), 0);
        drive(1'b1, 10);
        chk("fs_no_fin", n_fin - f0, 0);
        chk("fs_no_err", n_err - e0, 0);

        // Back-to-back "$GP".
        f0 = n_fin;
        send_frame(CH_DOLLAR, 1'b1, -1, 0);
        send_frame(8'h47, 1'b1, -1, 0);
        send_frame(8'h50, 1'b1, -1, 0);
        drive(1'b1, 20);
        chk("b2b_fin_cnt", n_fin - f0, 3);
        if (fin_times.size() >= 3) begin
            chk("b2b_gap1", fin_times[fin_times.size()-2] - fin_times[fin_times.size()-3], 160);
            chk("b2b_gap2", fin_times[fin_times.size()-1] - fin_times[fin_times.size()-2], 160);
        end
        chk("b2b_last_char", o_char, 8'h50);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            f0 = n_fin; e0 = n_err;
            send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].gbit, vecs[v].goff);
            drive(1'b1, 20);
            chk($sformatf("vec%0d_fin", v), n_fin - f0, vecs[v].exp_fin);
            chk($sformatf("vec%0d_err", v), n_err - e0, vecs[v].exp_err);
            chk($sformatf("vec%0d_char", v), o_char, vecs[v].exp_char);
            chk($sformatf("vec%0d_busy", v), 32'(o_busy), 0);
            if (vecs[v].exp_fin != 0) chk($sformatf("vec%0d_lat", v), last_fin_cyc - stop_cyc, LAT);
            else                      chk($sformatf("vec%0d_lat", v), last_err_cyc - stop_cyc, LAT);
        end

        // Reset in the middle of data bit 4 of 8'hFF.
        f0 = n_fin;
        drive(1'b0, CPB);
        drive(1'b1, 4 * CPB + HALF);
        chk("mr_busy_before", 32'(o_busy), 1);
        i_rst = 1'b0;
        i_rx  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("mr_char", o_char, 0);
            chk("mr_fin", 32'(o_finished), 0);
            chk("mr_err", 32'(o_frame_err), 0);
            chk("mr_busy", 32'(o_busy), 0);
        end
        i_rst = 1'b1;
        drive(1'b1, 4 * CPB);
        chk("mr_no_fin", n_fin - f0, 0);
        send_frame(CH_CR, 1'b1, -1, 0);
        drive(1'b1, 20);
        chk("mr_char_after", o_char, 8'h0D);
        chk("mr_fin_after", n_fin - f0, 1);

        // Randomized frames, glitches, framing errors and gaps.
        f0 = n_fin; good = 0;
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            gb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
            go  = int'($urandom_range(0, CPB - 1));
            gap = ok ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
            if (ok) good++;
            send_frame(d, ok, gb, go);
            drive(1'b1, gap);
        end
        drive(1'b1, 30);
        chk("rand_fin_cnt", n_fin - f0, good);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("err_total", n_err, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmea_uart_rx.md
Name: nmea_uart_rx

Overview:
- Serial front end of the NMEA receive path: asynchronous 8N1 UART deserializer.
- Turns the raw i_rx line into one byte per frame plus a one-cycle strobe.
- Directly feeds the NMEA sentence parser, whose o_char/o_finished inputs it drives.
- Adds false-start rejection, 3-sample majority voting and framing-error detection, so the parser only sees clean characters.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per bit period (50 MHz / 4800 baud NMEA default); legal range >= 8.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset; one clock; reset is asynchronous and active-low.
- i_rx  input  1  raw serial line; asynchronous; idle high.
- o_char  output  8  last correctly framed byte; held until the next valid byte.
- o_finished  output  1  one-cycle pulse: o_char was updated this cycle.
- o_frame_err  output  1  one-cycle pulse: stop bit was sampled low.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: o_char=8'h00, o_finished=0, o_frame_err=0, o_busy=0, state=IDLE, counters=0, shift register=0. Reset mid-frame discards the partial byte, emits no pulse, and restarts in IDLE.
- Synchronizer: i_rx passes through a 2-FF synchronizer (reset value 1) giving rx_s. All logic uses rx_s only; this adds 2 cycles of latency. rx_s is also registered to form rx_d for edge detection.
- Constants: HALF = CLKS_PER_BIT/2 (integer division). Sample points within a bit are baud_cnt = HALF-1, HALF and HALF+1; these three samples are majority-voted at HALF+1.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0. bit_cnt counts 0..DATA_BITS-1.
- IDLE: on rx_d=1 and rx_s=0 (falling edge), go to START with baud_cnt=0. No other transition.
- START: at HALF+1:
  - vote=1 → false start; go to IDLE with no outputs.
  - vote=0 → continue counting. On wrap, go to DATA with bit_cnt=0.
- DATA: at HALF+1 of each bit, shift the vote into bit DATA_BITS-1 of the shift register (right shift, LSB first). On wrap: if bit_cnt=DATA_BITS-1, go to STOP; else bit_cnt+1.
- STOP: at HALF+1:
  - vote=1 → on the next edge o_char<=shift register, o_finished=1 for exactly one cycle, state<=IDLE. IDLE is entered mid stop bit so a back-to-back start edge is caught.
  - vote=0 → o_frame_err=1 for one cycle, o_char unchanged, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. A line held low (break) produces exactly one o_frame_err.
- Latency: o_finished rises HALF+2 cycles after the synchronized stop-bit start, i.e. HALF+4 cycles after the raw i_rx stop-bit edge.
- o_finished and o_frame_err are never high in the same cycle.
- A glitch of 1 cycle at any single sample point is outvoted and must not change the received bit.
- The falling edge is re-armed only in IDLE. Edges seen during START/DATA/STOP are ignored.
- No FIFO or overrun handling: the consumer must take o_char within one frame time. This is guaranteed for the parser, which is single-cycle.

Decomposition:
- Shared package nmea_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
  - NMEA character constants ('$'=8'h24, '*'=8'h2A, CR=8'h0D, LF=8'h0A, ','=8'h2C), also used by the parser;
  - default CLKS_PER_BIT.
- One sub-module: rx_sync, a 2-flop synchronizer with parameterized reset value (here 1).
- Baud counter, majority vote and shift register stay inline.

Test Plan (CLKS_PER_BIT=16, bits driven for exactly 16 cycles):
- Idle line, then frame for 8'h24 → o_char=8'h24 with a single-cycle o_finished at stop-bit edge +12 cycles; o_frame_err stays 0; o_busy low afterwards.
- i_rx low for 4 cycles then high → no o_finished and no o_frame_err; o_busy returns to 0 within 12 cycles.
- Frame 8'h47 with stop bit low, line held low 40 cycles, then idle, then frame 8'h2A → exactly one o_frame_err; o_char stays 8'h00 through the error; then o_char=8'h2A with one o_finished.
- Back-to-back "$GP" (24 47 50) with zero idle between frames → three o_finished pulses exactly 160 cycles apart; bytes 24, 47, 50 in order.
- 1-cycle high glitch on sample HALF of data bit 3 in 8'h00 → o_char=8'h00 (outvoted).
- i_rst asserted at data bit 4 of 8'hFF, released, then frame 8'h0D → no pulse for the aborted byte; o_char=8'h0D; all outputs 0 while in reset.
